// File: rtl/branch_pkg.sv
// Shared encodings for the branch predictor: condition codes, 2-bit counter
// states and the counter values used at reset and on allocation.
package branch_pkg;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } func3_e;

   typedef enum logic [1:0] {
      CNT_SNT = 2'b00,
      CNT_WNT = 2'b01,
      CNT_WT  = 2'b10,
      CNT_ST  = 2'b11
   } ctr_e;

   localparam ctr_e CNT_RESET = CNT_WNT;
   localparam ctr_e CNT_ALLOC = CNT_WT;

   // 010 and 011 are not branch encodings
   function automatic logic func3_valid(input logic [2:0] f3);
      return (f3[2] == 1'b1) || (f3[1] == 1'b0);
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation; invalid condition codes
// report not-taken.
module branch_cond
   import branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic [2:0]      i_func3,
   output logic            o_taken
);

   always_comb begin
      o_taken = 1'b0;
      case (i_func3)
         F3_BEQ:  o_taken = (i_rs1 == i_rs2);
         F3_BNE:  o_taken = (i_rs1 != i_rs2);
         F3_BLT:  o_taken = ($signed(i_rs1) <  $signed(i_rs2));
         F3_BGE:  o_taken = ($signed(i_rs1) >= $signed(i_rs2));
         F3_BLTU: o_taken = (i_rs1 <  i_rs2);
         F3_BGEU: o_taken = (i_rs1 >= i_rs2);
         default: o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters,
// combinational lookup at fetch and resolve/redirect at execute.
module branch_predictor
   import branch_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic [2:0]      ex_func3,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_rs2,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   localparam int IDX  = $clog2(BHT_ENTRIES);
   localparam int TAGW = XLEN - IDX - 2;

   logic [BHT_ENTRIES-1:0]      r_valid;
   logic [BHT_ENTRIES-1:0][1:0] r_ctr;
   logic [TAGW-1:0]             r_tag    [BHT_ENTRIES];
   logic [XLEN-1:0]             r_target [BHT_ENTRIES];
   logic                        r_redirect_valid;
   logic [XLEN-1:0]             r_redirect_pc;

   logic [IDX-1:0]  w_if_idx;
   logic [TAGW-1:0] w_if_tag;
   logic            w_if_hit;
   logic [IDX-1:0]  w_ex_idx;
   logic [TAGW-1:0] w_ex_tag;
   logic            w_ex_hit;
   logic            w_fire;
   logic            w_f3_ok;
   logic            w_cond_taken;
   logic            w_act_taken;
   logic [XLEN-1:0] w_act_tgt;
   logic [XLEN-1:0] w_fall_pc;
   logic            w_mispred;
   logic            w_upd;
   logic            w_unused;

   assign w_unused = ^{if_pc[1:0], ex_pc[1:0]};

   assign w_if_idx    = if_pc[IDX+1:2];
   assign w_if_tag    = if_pc[XLEN-1:IDX+2];
   assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
   assign pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
   assign pred_target = pred_taken ? r_target[w_if_idx] : if_pc + XLEN'(4);

   branch_cond #(.XLEN(XLEN)) u_cond (
      .i_rs1   (ex_rs1),
      .i_rs2   (ex_rs2),
      .i_func3 (ex_func3),
      .o_taken (w_cond_taken)
   );

   assign w_ex_idx    = ex_pc[IDX+1:2];
   assign w_ex_tag    = ex_pc[XLEN-1:IDX+2];
   assign w_ex_hit    = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
   assign w_fire      = ex_valid && ex_branch;
   assign w_f3_ok     = func3_valid(ex_func3);
   assign w_act_taken = w_f3_ok && w_cond_taken;
   assign w_act_tgt   = ex_pc + ex_imm;
   assign w_fall_pc   = ex_pc + XLEN'(4);
   assign w_upd       = w_fire && w_f3_ok;
   // invalid func3 still resolves (as not-taken) so a taken prediction redirects
   assign w_mispred   = w_fire && ((w_act_taken != ex_pred_taken) ||
                        (w_act_taken && ex_pred_taken && (ex_pred_target != w_act_tgt)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_ctr   <= {BHT_ENTRIES{CNT_RESET}};
      end else if (w_upd) begin
         if (w_ex_hit) begin
            if (w_act_taken) begin
               if (r_ctr[w_ex_idx] != CNT_ST) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
            end else begin
               if (r_ctr[w_ex_idx] != CNT_SNT) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
            end
         end else if (w_act_taken) begin
            r_valid[w_ex_idx] <= 1'b1;
            r_ctr[w_ex_idx]   <= CNT_ALLOC;
         end
      end
   end

   // tag/target need no reset: they are only observed behind a valid bit
   always_ff @(posedge clk) begin
      if (w_upd && w_act_taken) begin
         r_tag[w_ex_idx]    <= w_ex_tag;
         r_target[w_ex_idx] <= w_act_tgt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_redirect_valid <= w_mispred;
         if (w_mispred) r_redirect_pc <= w_act_taken ? w_act_tgt : w_fall_pc;
      end
   end

   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed checks of branch_predictor against a table-level
// reference model.
module tb_branch_predictor;

   localparam int XLEN = 32;
   localparam int N    = 16;
   localparam int TSH  = $clog2(N) + 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [XLEN-1:0] if_pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            ex_valid, ex_branch, ex_pred_taken;
   logic [2:0]      ex_func3;
   logic [XLEN-1:0] ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_target;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   always #5 clk = ~clk;

   branch_predictor #(.XLEN(XLEN), .BHT_ENTRIES(N)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_branch      (ex_branch),
      .ex_func3       (ex_func3),
      .ex_rs1         (ex_rs1),
      .ex_rs2         (ex_rs2),
      .ex_pc          (ex_pc),
      .ex_imm         (ex_imm),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   bit              m_valid [N];
   logic [XLEN-1:0] m_tag   [N];
   logic [XLEN-1:0] m_tgt   [N];
   int              m_ctr   [N];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [XLEN-1:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] pc);
      return pc >> TSH;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
   endtask

   task automatic model_lookup(input logic [XLEN-1:0] pc, output bit t, output logic [XLEN-1:0] tg);
      int i;
      i  = idx_of(pc);
      t  = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
      tg = t ? m_tgt[i] : pc + 32'd4;
   endtask

   function automatic bit ref_taken(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) <  $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic set_resolve(input bit v, input bit br, input logic [2:0] f3,
                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                              input bit pt, input logic [XLEN-1:0] ptg);
      ex_valid = v; ex_branch = br; ex_func3 = f3; ex_rs1 = a; ex_rs2 = b;
      ex_pc = pc; ex_imm = imm; ex_pred_taken = pt; ex_pred_target = ptg;
   endtask

   // One clock: check lookup before the edge, advance model, check redirect after.
   task automatic step();
      bit              lt, act, mis, exp_rv;
      logic [XLEN-1:0] ltg, tgt, exp_rpc;
      int              i;
      @(negedge clk);
      model_lookup(if_pc, lt, ltg);
      check_eq("pred_taken", {31'd0, pred_taken}, {31'd0, lt});
      check_eq("pred_target", pred_target, ltg);
      exp_rv = 1'b0; exp_rpc = '0;
      if (ex_valid && ex_branch) begin
         act = ref_taken(ex_func3, ex_rs1, ex_rs2);
         tgt = ex_pc + ex_imm;
         mis = (act != ex_pred_taken) || (act && ex_pred_taken && ex_pred_target != tgt);
         exp_rv = mis;
         exp_rpc = act ? tgt : ex_pc + 32'd4;
         if (ex_func3 != 3'd2 && ex_func3 != 3'd3) begin
            i = idx_of(ex_pc);
            if (m_valid[i] && m_tag[i] == tag_of(ex_pc)) begin
               m_ctr[i] = act ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
               if (act) m_tgt[i] = tgt;
            end else if (act) begin
               m_valid[i] = 1'b1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = tgt; m_ctr[i] = 2;
            end
         end
      end
      @(posedge clk);
      #1;
      check_eq("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_rv});
      if (exp_rv) check_eq("redirect_pc", redirect_pc, exp_rpc);
   endtask

   function automatic logic [XLEN-1:0] rand_pc();
      logic [XLEN-1:0] tags [4];
      tags[0] = 32'd0; tags[1] = 32'd1; tags[2] = 32'd4; tags[3] = 32'h03FF_FFFF;
      return (tags[$urandom_range(3)] << TSH) | (XLEN'($urandom_range(N - 1)) << 2);
   endfunction

   function automatic logic [XLEN-1:0] rand_op();
      logic [XLEN-1:0] ops [4];
      ops[0] = 32'd0; ops[1] = 32'd5; ops[2] = 32'hFFFF_FFFF; ops[3] = 32'h8000_0000;
      return ($urandom_range(3) == 0) ? XLEN'($urandom) : ops[$urandom_range(3)];
   endfunction

   initial begin
      bit              mt;
      logic [XLEN-1:0] mtg, pc;
      rst_n = 1'b0;
      if_pc = 32'h100;
      set_resolve(0, 0, 3'd0, '0, '0, '0, '0, 0, '0);
      model_reset();
      #1;
      check_eq("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      check_eq("reset_redirect_pc", redirect_pc, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // fresh table: lookup at 0x100 falls through
      check_eq("reset_lookup_taken", {31'd0, pred_taken}, 32'd0);
      check_eq("reset_lookup_target", pred_target, 32'h104);

      // BEQ taken miss allocates and redirects to 0x140
      set_resolve(1, 1, 3'd0, 5, 5, 32'h100, 32'h40, 0, 32'h104);
      step();
      check_eq("beq_redirect_pc", redirect_pc, 32'h140);
      set_resolve(0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
      #1;
      check_eq("beq_lookup_taken", {31'd0, pred_taken}, 32'd1);
      check_eq("beq_lookup_target", pred_target, 32'h140);

      // three correct taken, then two not-taken
      repeat (3) begin
         set_resolve(1, 1, 3'd0, 5, 5, 32'h100, 32'h40, 1, 32'h140);
         step();
      end
      repeat (2) begin
         model_lookup(32'h100, mt, mtg);
         set_resolve(1, 1, 3'd0, 5, 6, 32'h100, 32'h40, mt, mtg);
         step();
      end
      set_resolve(0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
      #1;
      check_eq("after_2nt_taken", {31'd0, pred_taken}, 32'd0);

      // signed vs unsigned compare
      set_resolve(1, 1, 3'd4, 32'hFFFF_FFFF, 1, 32'h200, 32'h10, 0, 32'h204);
      step();
      set_resolve(1, 1, 3'd6, 32'hFFFF_FFFF, 1, 32'h300, 32'h10, 0, 32'h304);
      step();

      // wrap of fall-through and an invalid condition code
      set_resolve(1, 1, 3'd1, 7, 7, 32'hFFFF_FFFC, 32'h20, 1, 32'h1C);
      step();
      check_eq("wrap_redirect_pc", redirect_pc, 32'h0);
      set_resolve(1, 1, 3'd2, 1, 2, 32'h100, 32'h40, 1, 32'h140);
      if_pc = 32'h100;
      step();
      step();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         pc = rand_pc();
         if ($urandom_range(1) == 0) model_lookup(pc, mt, mtg);
         else begin
            mt  = 1'($urandom);
            mtg = ($urandom_range(1) == 0) ? pc + 32'd4 : rand_pc();
         end
         set_resolve($urandom_range(3) != 0, $urandom_range(4) != 0, 3'($urandom),
                     rand_op(), rand_op(), pc, ($urandom_range(1) == 0) ? 32'h40 : rand_pc(), mt, mtg);
         if_pc = ($urandom_range(1) == 0) ? pc : rand_pc();
         step();
      end

      // reset right after a mispredict resolve discards the redirect
      set_resolve(1, 1, 3'd0, 7, 7, 32'h200, 32'h8, 0, 32'h204);
      step();
      rst_n = 1'b0;
      set_resolve(0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #1;
      check_eq("midreset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      check_eq("midreset_redirect_pc", redirect_pc, 32'd0);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      for (int n = 0; n < 16; n++) begin
         if_pc = (n < 2) ? ((n == 0) ? 32'h200 : 32'h100) : rand_pc();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
